preset_router: RTL
==================

Name: preset_router

Overview:
- Parametrised successor to the clock's preset splitter.
- Captures a packed BCD time word on request, validates it and normalises 12h input to 24h BCD.
- Drives the preset onto shared pre_sec/pre_min/pre_hour buses and delivers it to one of NUM_TARGETS loadable units (clock, alarm, counter, ...) with a one-hot PE strobe and a per-target acknowledge handshake.
- Sits between the keypad/display-edit logic and the time-keeping units.

Parameters:
- NUM_TARGETS, 3, number of loadable units; PE/pe_ack width (0=clock, 1=alarm, 2=counter).
- ACK_TIMEOUT, 15, max LOAD cycles waiting for pe_ack before abort (1..255).
- TSEL_W, 2, width of target_sel; must satisfy 2**TSEL_W >= NUM_TARGETS.

Ports:
- CP  in  1  system clock, rising edge.
- _CR  in  1  asynchronous active-low reset/clear.
- display_time  in  32  [7:0] sec BCD, [15:8] min BCD, [23:16] hour BCD, [24] PM flag (12h only), [31:25] ignored.
- time_mode  in  1  0 = display_time hour is 24h; 1 = 12h with PM flag.
- target_sel  in  TSEL_W  destination index, sampled with load_req.
- load_req  in  1  start request, level-sampled in IDLE.
- pe_ack  in  NUM_TARGETS  per-target load acknowledge.
- pre_sec  out  8  registered preset seconds, BCD.
- pre_min  out  8  registered preset minutes, BCD.
- pre_hour  out  8  registered preset hours, 24h BCD.
- PE  out  NUM_TARGETS  one-hot load enable, registered.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of every accepted request.
- err_code  out  2  00 ok, 01 bad BCD/range, 10 ack timeout, 11 bad target; held until next accepted request.

Behaviour:
- Reset (_CR=0, async): state=IDLE; pre_*=8'h00; PE=0; busy=0; done=0; err_code=00; timeout counter=0. Reset mid-LOAD drops PE immediately.
- States: IDLE, CHECK, LOAD, DONE.
- IDLE: on edge with load_req=1, capture display_time, time_mode and target_sel; clear err_code; go to CHECK.
- CHECK (1 cycle), validation rules:
  - every nibble <= 9;
  - sec/min tens <= 5;
  - 24h hour <= 0x23;
  - 12h hour in 0x01..0x12.
- CHECK outcomes:
  - target_sel >= NUM_TARGETS -> err 11, go to DONE.
  - Invalid field -> err 01, go to DONE; pre_* unchanged.
  - Otherwise load pre_* with the converted value and go to LOAD.
- 12h -> 24h conversion:
  - PM=0: 12 -> 00, else unchanged.
  - PM=1: 12 -> 12, else BCD +12 (01 -> 13, 09 -> 21, 10 -> 22, 11 -> 23).
  - PM is ignored in 24h mode.
- LOAD:
  - PE[sel]=1 from the first LOAD cycle (two cycles after the accepting edge); pre_* are stable no later than PE rises.
  - When pe_ack[sel]=1 is sampled (including on the first LOAD cycle), drop PE next cycle and go to DONE.
  - Acks on other channels are ignored.
  - After ACK_TIMEOUT LOAD cycles without ack: drop PE, err 10, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- load_req while busy is ignored (no queueing); a still-high load_req in the IDLE cycle after DONE starts a new request.
- pre_* hold their last valid value indefinitely.
- Timeout counter is cleared on entry to LOAD.

Optional Feature:
- Macro PRESET_CLAMP_EN.
- Defined: BCD-valid but out-of-range fields are clamped (sec/min > 59 -> 0x59, 24h hour > 23 -> 0x23); the request proceeds with err 00. Non-BCD nibbles and bad 12h hours (00, >12) still give err 01.
- Undefined: any out-of-range field is rejected with err 01.

Decomposition:
- Shared package clock_pkg holds:
  - BCD limit constants (SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR24_MAX=8'h23, HOUR12_MAX=8'h12);
  - err_code values (ERR_OK, ERR_RANGE, ERR_TIMEOUT, ERR_TARGET);
  - the state enum type.
- One combinational sub-module, bcd_time_check: validates and converts a captured word to 24h BCD and outputs a valid flag. The FSM stays in preset_router.

Test Plan:
- 24h load to alarm: display_time=32'h00_23_45_10, time_mode=0, sel=1, ack after 3 cycles -> PE=3'b010 for 4 cycles, pre=23:45:10, done pulse, err 00.
- 12h PM conversion: hour 0x09, PM=1, sel=0, immediate ack -> pre_hour=0x21, PE held for exactly 1 cycle. Also hour 0x12, PM=0 -> pre_hour=0x00.
- Invalid BCD: sec=0x6A -> no PE, err 01, done pulse 2 cycles after accept, pre_* unchanged. With PRESET_CLAMP_EN, sec=0x75 -> pre_sec=0x59, err 00.
- Timeout: sel=2, pe_ack never asserted -> PE[2] high exactly 15 cycles, then err 10, done.
- Busy/bad target: load_req held high during LOAD -> ignored until IDLE. sel=3 with NUM_TARGETS=3 -> err 11, no PE.
- Reset mid-LOAD: _CR low asynchronously -> PE=0, busy=0, pre_*=00 immediately; next request proceeds normally.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants, state type and BCD helpers for the time-preset path.
package clock_pkg;

  localparam logic [7:0] SEC_MAX    = 8'h59;
  localparam logic [7:0] MIN_MAX    = 8'h59;
  localparam logic [7:0] HOUR24_MAX = 8'h23;
  localparam logic [7:0] HOUR12_MAX = 8'h12;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_TARGET  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic nib_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // BCD +12 for hours 01..11; a low digit of 8/9 only occurs with tens 0.
  function automatic logic [7:0] add12_bcd(input logic [7:0] h);
    return (h[3:0] >= 4'd8) ? (h + 8'h18) : (h + 8'h12);
  endfunction

endpackage

// File: rtl/bcd_time_check.sv
// Validates a captured BCD time word and converts it to 24h BCD.
// PRESET_CLAMP_EN: clamp BCD-valid out-of-range sec/min/24h-hour instead of rejecting.
module bcd_time_check
  import clock_pkg::*;
(
  input  logic [24:0] time_word,
  input  logic        mode12,
  output logic [7:0]  sec_o,
  output logic [7:0]  min_o,
  output logic [7:0]  hour_o,
  output logic        valid
);

  logic [7:0] sec, min, hour, hour24, hour12;
  logic       pm, sec_ok, min_ok, h24_ok, h12_ok;

  always_comb begin
    sec  = time_word[7:0];
    min  = time_word[15:8];
    hour = time_word[23:16];
    pm   = time_word[24];
`ifdef PRESET_CLAMP_EN
    sec_o  = (sec > SEC_MAX) ? SEC_MAX : sec;
    min_o  = (min > MIN_MAX) ? MIN_MAX : min;
    hour24 = (hour > HOUR24_MAX) ? HOUR24_MAX : hour;
    sec_ok = nib_ok(sec);
    min_ok = nib_ok(min);
    h24_ok = nib_ok(hour);
`else
    sec_o  = sec;
    min_o  = min;
    hour24 = hour;
    sec_ok = nib_ok(sec) && (sec <= SEC_MAX);
    min_ok = nib_ok(min) && (min <= MIN_MAX);
    h24_ok = nib_ok(hour) && (hour <= HOUR24_MAX);
`endif
    h12_ok = nib_ok(hour) && (hour != 8'h00) && (hour <= HOUR12_MAX);
    // 12 AM is midnight (00), 12 PM stays 12, other PM hours gain 12.
    if (pm) hour12 = (hour == HOUR12_MAX) ? HOUR12_MAX : add12_bcd(hour);
    else    hour12 = (hour == HOUR12_MAX) ? 8'h00 : hour;
    hour_o = mode12 ? hour12 : hour24;
    valid  = sec_ok && min_ok && (mode12 ? h12_ok : h24_ok);
  end

endmodule

// File: rtl/preset_router.sv
// Captures a BCD time preset, validates/normalises it and delivers it to one
// of NUM_TARGETS units with a one-hot PE strobe and per-target ack.
// Optional macro PRESET_CLAMP_EN (see bcd_time_check) clamps out-of-range fields.
//
// Handshake: a target loads pre_* while its PE bit is high; it answers by
// raising its pe_ack bit, which ends the strobe on the following edge.
module preset_router
  import clock_pkg::*;
#(
  parameter int NUM_TARGETS = 3,
  parameter int ACK_TIMEOUT = 15,
  parameter int TSEL_W      = 2
) (
  input  logic                   CP,
  input  logic                   _CR,
  input  logic [31:0]            display_time,
  input  logic                   time_mode,
  input  logic [TSEL_W-1:0]      target_sel,
  input  logic                   load_req,
  input  logic [NUM_TARGETS-1:0] pe_ack,
  output logic [7:0]             pre_sec,
  output logic [7:0]             pre_min,
  output logic [7:0]             pre_hour,
  output logic [NUM_TARGETS-1:0] PE,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             err_code,
  output logic [1:0]             state_dbg
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [24:0]            cap_q, cap_d;
  logic                   mode_q, mode_d;
  logic [TSEL_W-1:0]      sel_q, sel_d;
  logic [7:0]             pre_sec_q, pre_sec_d, pre_min_q, pre_min_d, pre_hour_q, pre_hour_d;
  logic [NUM_TARGETS-1:0] pe_q, pe_d, sel_onehot;
  logic [1:0]             err_q, err_d;
  logic [7:0]             cnt_q, cnt_d;

  logic [7:0] chk_sec, chk_min, chk_hour;
  logic       chk_valid;
  logic       unused_time_bits;

  assign unused_time_bits = ^display_time[31:25];

  bcd_time_check u_check (
    .time_word (cap_q),
    .mode12    (mode_q),
    .sec_o     (chk_sec),
    .min_o     (chk_min),
    .hour_o    (chk_hour),
    .valid     (chk_valid)
  );

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_TARGETS; i++) sel_onehot[i] = (int'(sel_q) == i);
  end

  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      state_q    <= S_IDLE;
      cap_q      <= '0;
      mode_q     <= 1'b0;
      sel_q      <= '0;
      pre_sec_q  <= 8'h00;
      pre_min_q  <= 8'h00;
      pre_hour_q <= 8'h00;
      pe_q       <= '0;
      err_q      <= ERR_OK;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      pre_sec_q  <= pre_sec_d;
      pre_min_q  <= pre_min_d;
      pre_hour_q <= pre_hour_d;
      pe_q       <= pe_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    pre_sec_d  = pre_sec_q;
    pre_min_d  = pre_min_q;
    pre_hour_d = pre_hour_q;
    pe_d       = pe_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          cap_d   = display_time[24:0];
          mode_d  = time_mode;
          sel_d   = target_sel;
          err_d   = ERR_OK;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (int'(sel_q) >= NUM_TARGETS) begin
          err_d   = ERR_TARGET;
          state_d = S_DONE;
        end else if (!chk_valid) begin
          err_d   = ERR_RANGE;
          state_d = S_DONE;
        end else begin
          pre_sec_d  = chk_sec;
          pre_min_d  = chk_min;
          pre_hour_d = chk_hour;
          pe_d       = sel_onehot;
          cnt_d      = 8'd0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        // pe_q is one-hot on the selected target, so this ignores foreign acks.
        if (|(pe_ack & pe_q)) begin
          pe_d    = '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          pe_d    = '0;
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
    pre_sec   = pre_sec_q;
    pre_min   = pre_min_q;
    pre_hour  = pre_hour_q;
    PE        = pe_q;
    err_code  = err_q;
  end

endmodule
